nic_cmd_responder: RTL

- Responder end of the HPU command path for NIC outbound sends.
- Accepts pspin_cmd_t commands from the command unit on the CMD_NIC_OUTBOUND_ID interface.
- Segments each NICSend into packet requests of at most MAX_PKT_SIZE bytes and issues them to the NIC outbound engine.
- Returns one pspin_cmd_resp_t per command, in acceptance order, once every packet of that command is reported done. The HPU uses these responses to free its command slots.

---
 rtl/nic_cmd_responder_if.sv | 77 +++++++
 rtl/nic_cmd_responder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/nic_cmd_responder_if.sv
// PsPIN command/response types and the handshake bundle between the
// command unit, the NIC outbound engine and the NIC command responder.
package nic_cmd_pkg;

    typedef enum logic [1:0] {
        HostMemCpy = 2'd0,
        NICSend    = 2'd1,
        HostDirect = 2'd2
    } pspin_cmd_type_t;

    typedef struct packed {
        logic [7:0]  cluster_id;
        logic [7:0]  core_id;
        logic [15:0] local_cmd_id;
    } pspin_cmd_id_t;

    typedef struct packed {
        logic [31:0] nid;
        logic [31:0] fid;
        logic [63:0] src_addr;
        logic [31:0] length;
        logic [63:0] user_ptr;
    } nic_cmd_t;

    typedef struct packed {
        pspin_cmd_id_t   cmd_id;
        logic            generate_event;
        pspin_cmd_type_t cmd_type;
        nic_cmd_t        descr;
    } pspin_cmd_t;

    typedef struct packed {
        pspin_cmd_id_t cmd_id;
        logic [63:0]   imm_data;
    } pspin_cmd_resp_t;

endpackage

interface nic_cmd_responder_if #(
    parameter int unsigned CMD_FIFO_DEPTH = 8
);
    import nic_cmd_pkg::*;

    logic                              cmd_valid_i;
    logic                              cmd_ready_o;
    pspin_cmd_t                        cmd_i;
    logic                              pkt_valid_o;
    logic                              pkt_ready_i;
    logic [31:0]                       pkt_nid_o;
    logic [31:0]                       pkt_fid_o;
    logic [63:0]                       pkt_src_addr_o;
    logic [31:0]                       pkt_len_o;
    logic [63:0]                       pkt_user_ptr_o;
    logic                              pkt_last_o;
    logic                              done_valid_i;
    logic                              done_ready_o;
    logic                              resp_valid_o;
    logic                              resp_ready_i;
    pspin_cmd_resp_t                   resp_o;
    logic                              illegal_cmd_o;
    logic [$clog2(CMD_FIFO_DEPTH):0]   in_flight_o;

    modport slave (
        input  cmd_valid_i, cmd_i, pkt_ready_i, done_valid_i, resp_ready_i,
        output cmd_ready_o, pkt_valid_o, pkt_nid_o, pkt_fid_o, pkt_src_addr_o,
               pkt_len_o, pkt_user_ptr_o, pkt_last_o, done_ready_o,
               resp_valid_o, resp_o, illegal_cmd_o, in_flight_o
    );

    modport master (
        output cmd_valid_i, cmd_i, pkt_ready_i, done_valid_i, resp_ready_i,
        input  cmd_ready_o, pkt_valid_o, pkt_nid_o, pkt_fid_o, pkt_src_addr_o,
               pkt_len_o, pkt_user_ptr_o, pkt_last_o, done_ready_o,
               resp_valid_o, resp_o, illegal_cmd_o, in_flight_o
    );

endinterface

// File: rtl/nic_cmd_responder.sv
// NIC outbound command responder: splits NICSend commands into packet requests
// and returns one in-order response per command once all its packets are done.
module nic_cmd_responder
    import nic_cmd_pkg::*;
#(
    parameter int unsigned MAX_PKT_SIZE   = 1024,
    parameter int unsigned CMD_FIFO_DEPTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    nic_cmd_responder_if.slave bus
);
    localparam int unsigned PKT_SHIFT = $clog2(MAX_PKT_SIZE);
    localparam int unsigned AW        = $clog2(CMD_FIFO_DEPTH);
    localparam int unsigned CW        = AW + 1;
    localparam logic [32:0]   PKT_MAX33 = 33'(MAX_PKT_SIZE);
    localparam logic [31:0]   PKT_MAX32 = 32'(MAX_PKT_SIZE);
    localparam logic [CW-1:0] FULL_CNT  = CW'(CMD_FIFO_DEPTH);

    typedef enum logic {IDLE, ISSUE} state_e;

    state_e        state_q, state_d;
    logic [31:0]   nid_q, nid_d, fid_q, fid_d, rem_q, rem_d;
    logic [63:0]   src_q, src_d, uptr_q, uptr_d;

    pspin_cmd_id_t id_mem_q  [CMD_FIFO_DEPTH];
    logic [32:0]   nch_mem_q [CMD_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [32:0]   done_cnt_q, done_cnt_d;
    logic          popped_q, illegal_q;

    logic          cmd_ready, accept, is_send, fifo_full, fifo_empty;
    logic [32:0]   nchunks_raw, nchunks;
    logic          pkt_valid, pkt_last, pkt_fire;
    logic [31:0]   pkt_len;
    pspin_cmd_id_t head_id;
    logic [32:0]   head_nch;
    logic          resp_valid, resp_fire, done_ready, done_fire;

    assign fifo_full   = (count_q == FULL_CNT);
    assign fifo_empty  = (count_q == '0);
    assign accept      = bus.cmd_valid_i && cmd_ready;
    assign is_send     = (bus.cmd_i.cmd_type == NICSend);
    // 33-bit sum so lengths near 2^32 do not wrap before the shift
    assign nchunks_raw = ({1'b0, bus.cmd_i.descr.length} + PKT_MAX33 - 33'd1) >> PKT_SHIFT;
    assign nchunks     = is_send ? nchunks_raw : '0;
    assign pkt_fire    = pkt_valid && bus.pkt_ready_i;
    assign head_id     = id_mem_q[rd_ptr_q];
    assign head_nch    = nch_mem_q[rd_ptr_q];
    assign resp_fire   = resp_valid && bus.resp_ready_i;
    assign done_fire   = bus.done_valid_i && done_ready;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept && nchunks != '0) state_d = ISSUE;
            ISSUE:   if (pkt_fire && pkt_last)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready  = (state_q == IDLE) && !fifo_full && !rst_i;
        pkt_valid  = (state_q == ISSUE);
        pkt_last   = (rem_q <= PKT_MAX32);
        pkt_len    = pkt_last ? rem_q : PKT_MAX32;
        // popped_q blanks the cycle after a pop so the new head is settled
        resp_valid = !fifo_empty && (done_cnt_q == head_nch) && !popped_q;
        done_ready = !fifo_empty && (head_nch != '0) && (done_cnt_q < head_nch) && !resp_valid;
    end

    assign bus.cmd_ready_o        = cmd_ready;
    assign bus.pkt_valid_o        = pkt_valid;
    assign bus.pkt_nid_o          = nid_q;
    assign bus.pkt_fid_o          = fid_q;
    assign bus.pkt_src_addr_o     = src_q;
    assign bus.pkt_len_o          = pkt_len;
    assign bus.pkt_user_ptr_o     = uptr_q;
    assign bus.pkt_last_o         = pkt_last;
    assign bus.done_ready_o       = done_ready;
    assign bus.resp_valid_o       = resp_valid;
    assign bus.resp_o.cmd_id      = head_id;
    assign bus.resp_o.imm_data    = '0;
    assign bus.illegal_cmd_o      = illegal_q;
    assign bus.in_flight_o        = count_q;

    always_comb begin
        nid_d  = nid_q;
        fid_d  = fid_q;
        src_d  = src_q;
        rem_d  = rem_q;
        uptr_d = uptr_q;
        if (accept && nchunks != '0) begin
            nid_d  = bus.cmd_i.descr.nid;
            fid_d  = bus.cmd_i.descr.fid;
            src_d  = bus.cmd_i.descr.src_addr;
            rem_d  = bus.cmd_i.descr.length;
            uptr_d = bus.cmd_i.descr.user_ptr;
        end else if (pkt_fire) begin
            src_d = src_q + 64'(pkt_len);
            rem_d = rem_q - pkt_len;
        end
    end

    always_comb begin
        count_d = count_q;
        if (accept && !resp_fire) begin
            count_d = count_q + CW'(1);
        end else if (!accept && resp_fire) begin
            count_d = count_q - CW'(1);
        end
        done_cnt_d = done_cnt_q;
        if (resp_fire) begin
            done_cnt_d = '0;
        end else if (done_fire) begin
            done_cnt_d = done_cnt_q + 33'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            nid_q      <= '0;
            fid_q      <= '0;
            src_q      <= '0;
            rem_q      <= '0;
            uptr_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            done_cnt_q <= '0;
            popped_q   <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            nid_q      <= nid_d;
            fid_q      <= fid_d;
            src_q      <= src_d;
            rem_q      <= rem_d;
            uptr_q     <= uptr_d;
            count_q    <= count_d;
            done_cnt_q <= done_cnt_d;
            popped_q   <= resp_fire;
            illegal_q  <= accept && !is_send;
            if (accept)    wr_ptr_q <= wr_ptr_q + AW'(1);
            if (resp_fire) rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            id_mem_q[wr_ptr_q]  <= bus.cmd_i.cmd_id;
            nch_mem_q[wr_ptr_q] <= nchunks;
        end
    end

    a_resp_has_head: assert property (@(posedge clk_i) disable iff (rst_i)
        bus.resp_valid_o |-> !fifo_empty);
    a_pkt_len_nonzero: assert property (@(posedge clk_i) disable iff (rst_i)
        bus.pkt_valid_o |-> (bus.pkt_len_o != '0));
    a_cmd_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (bus.cmd_valid_i && !bus.cmd_ready_o) |=> $stable(bus.cmd_i));

endmodule
